// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the sequential 74181-style ALU slice engine:
//   opcode width, the named opcodes of the {mode, sel[3:0]} encoding, and
//   the control FSM state type.
//   No ports; imported by the interface, the slice model and the top.

package alu_pkg;

  localparam int OP_W = 5;

  // Named opcodes, {mode, sel[3:0]} with active-high data.
  localparam logic [OP_W-1:0] ADD_OP            = 5'b0_1001;
  localparam logic [OP_W-1:0] SUB_OP            = 5'b0_0110;
  localparam logic [OP_W-1:0] A_PLUS_A_OP       = 5'b0_1100;
  localparam logic [OP_W-1:0] A_PLUS_A_AND_B_OP = 5'b0_1000;
  localparam logic [OP_W-1:0] AND_OP            = 5'b1_1011;
  localparam logic [OP_W-1:0] OR_OP             = 5'b1_1110;
  localparam logic [OP_W-1:0] XOR_OP            = 5'b1_0110;
  localparam logic [OP_W-1:0] INV_B_OP          = 5'b1_0101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_slice_seq_if.sv
// alu_slice_seq_if
//   Operand/result handshake bundle between the register file side (master)
//   and the sequential ALU (slave).
//   Signals: in_valid/in_ready, a, b, op, cin_n, chain (request side);
//            out_valid/out_ready, result, cout_n, zero (response side).

interface alu_slice_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             cin_n;
  logic             chain;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout_n;
  logic             zero;

  modport master (
    output in_valid, a, b, op, cin_n, chain, out_ready,
    input  in_ready, out_valid, result, cout_n, zero
  );

  modport slave (
    input  in_valid, a, b, op, cin_n, chain, out_ready,
    output in_ready, out_valid, result, cout_n, zero
  );

endinterface

// File: rtl/alu_181_slice.sv
// alu_181_slice
//   Combinational 4-bit 74181 model, active-high data, active-low carries.
//   Ports: a, b (4-bit operands), mode (1 = logic), sel (function select),
//          cn_n (carry in) -> f (4-bit result), cn4_n (carry out),
//          p_n / g_n (group propagate / generate for a 74182 lookahead).

module alu_181_slice
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       mode,
  input  logic [3:0] sel,
  input  logic       cn_n,
  output logic [3:0] f,
  output logic       cn4_n,
  output logic       p_n,
  output logic       g_n
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_sum;
  logic       w_cy;

  // Each bit forms a propagate term (a | b&s0 | ~b&s1) and a generate term
  // (a&~b&s2 | a&b&s3); arithmetic is simply w_p + w_g + carry, and logic
  // mode is the carry-free ~(p ^ g). The carry chain runs in both modes,
  // just like the real part, so cn4_n is valid even for logic opcodes.
  always_comb begin
    w_p   = a | (b & {4{sel[0]}}) | (~b & {4{sel[1]}});
    w_g   = (a & ~b & {4{sel[2]}}) | (a & b & {4{sel[3]}});
    w_sum = '0;
    w_cy  = ~cn_n;
    for (int i = 0; i < 4; i++) begin
      w_sum[i] = w_p[i] ^ w_g[i] ^ w_cy;
      w_cy     = w_g[i] | (w_p[i] & w_cy);
    end
    f     = mode ? ~(w_p ^ w_g) : w_sum;
    cn4_n = ~w_cy;
    p_n   = ~(&w_p);
    g_n   = ~(w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) |
              (w_p[3] & w_p[2] & w_p[1] & w_g[0]));
  end

endmodule

// File: rtl/alu_slice_seq.sv
// alu_slice_seq
//   Multi-cycle ALU: processes a WIDTH-bit operand pair LSB first as
//   4-bit 74181 slices, SLICES_PER_CYCLE slices per clock, with a
//   registered ripple carry between beats and an optional chained carry
//   for multi-precision arithmetic.
//   Ports: clk, rst_n (async, active-low), io_bus (alu_slice_seq_if.slave).

module alu_slice_seq
  import alu_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int SLICES_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_slice_seq_if.slave io_bus
);

  localparam int BW      = 4 * SLICES_PER_CYCLE;
  localparam int N_BEATS = WIDTH / BW;
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  state_t              r_state;
  state_t              w_nextState;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [OP_W-1:0]     r_op;
  logic                r_carryN;
  logic                r_cyN;
  logic [BEAT_W-1:0]   r_beat;
  logic [WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]    r_result;
  logic                r_coutN;
  logic                r_zero;

  logic                w_inReady;
  logic                w_outValid;
  logic                w_accept;
  logic                w_beatEn;
  logic                w_lastBeat;
  logic [BW-1:0]       w_beatF;
  logic                w_beatCoutN;
  logic [WIDTH-1:0]    w_accNext;
  logic [SLICES_PER_CYCLE-1:0] w_unusedPN;
  logic [SLICES_PER_CYCLE-1:0] w_unusedGN;

  assign w_lastBeat = (r_beat == BEAT_W'(N_BEATS - 1));

  // Operands shift right one beat at a time, so the slices always look at
  // the low BW bits; the carry ripples through the slices of this beat via
  // per-iteration wires. p_n/g_n are kept only for a future 74182 variant.
  for (genvar k = 0; k < SLICES_PER_CYCLE; k++) begin : g_slice
    logic w_cIn;
    logic w_cOut;
    if (k == 0) begin : g_first
      assign w_cIn = r_carryN;
    end else begin : g_next
      assign w_cIn = g_slice[k-1].w_cOut;
    end
    alu_181_slice u_slice (
      .a     (r_a[4*k +: 4]),
      .b     (r_b[4*k +: 4]),
      .mode  (r_op[4]),
      .sel   (r_op[3:0]),
      .cn_n  (w_cIn),
      .f     (w_beatF[4*k +: 4]),
      .cn4_n (w_cOut),
      .p_n   (w_unusedPN[k]),
      .g_n   (w_unusedGN[k])
    );
  end

  assign w_beatCoutN = g_slice[SLICES_PER_CYCLE-1].w_cOut;

  // Result bits enter at the top of the accumulator and move down, so after
  // the last beat the first (least significant) slice lands at bit 0.
  assign w_accNext = (r_acc >> BW) | (WIDTH'(w_beatF) << (WIDTH - BW));

  // State register for the IDLE -> RUN -> DONE sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake decode. in_valid is only looked at in IDLE,
  // so a request arriving together with out_ready in DONE waits a cycle.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    w_accept    = 1'b0;
    w_beatEn    = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (io_bus.in_valid) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_beatEn = 1'b1;
        if (w_lastBeat) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_outValid = 1'b1;
        if (io_bus.out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: latch the request on accept, step one beat per RUN cycle, and
  // publish result/flags only on the last beat so the outputs stay frozen
  // for the whole DONE phase. r_cyN remembers the final carry for chaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_carryN <= 1'b1;
      r_cyN    <= 1'b1;
      r_beat   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_coutN  <= 1'b1;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= io_bus.a;
      r_b      <= io_bus.b;
      r_op     <= io_bus.op;
      r_carryN <= io_bus.chain ? r_cyN : io_bus.cin_n;
      r_beat   <= '0;
    end else if (w_beatEn) begin
      r_a      <= r_a >> BW;
      r_b      <= r_b >> BW;
      r_acc    <= w_accNext;
      r_carryN <= w_beatCoutN;
      r_beat   <= r_beat + BEAT_W'(1);
      if (w_lastBeat) begin
        r_result <= w_accNext;
        r_coutN  <= w_beatCoutN;
        r_cyN    <= w_beatCoutN;
        r_zero   <= (w_accNext == '0);
      end
    end
  end

  assign io_bus.in_ready  = w_inReady;
  assign io_bus.out_valid = w_outValid;
  assign io_bus.result    = r_result;
  assign io_bus.cout_n    = r_coutN;
  assign io_bus.zero      = r_zero;

endmodule

// File: tb/tb_alu_slice_seq.sv
// tb_alu_slice_seq
//   Self-checking bench for alu_slice_seq: a 16-bit/1-slice instance and a
//   32-bit/2-slice instance, checked against a word-level 74181 function
//   table model.

module tb_alu_slice_seq;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic expCy16;
  logic expCy32;

  alu_slice_seq_if #(.WIDTH(16)) if16 ();
  alu_slice_seq_if #(.WIDTH(32)) if32 ();

  alu_slice_seq #(.WIDTH(16), .SLICES_PER_CYCLE(1)) dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (if16)
  );

  alu_slice_seq #(.WIDTH(32), .SLICES_PER_CYCLE(2)) dut32 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (if32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level 74181 model: arithmetic is the datasheet "X plus Y" table
  // evaluated as integers over w bits; logic mode is the datasheet's
  // per-function table. The carry is always the arithmetic one.
  task automatic refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cinN, input int w,
                          output logic [31:0] f, output logic coutN);
    logic [32:0] ones, aa, bb, na, nb, x, y, sum, lf;
    ones = (33'd1 << w) - 33'd1;
    aa   = {1'b0, a} & ones;
    bb   = {1'b0, b} & ones;
    na   = ~aa & ones;
    nb   = ~bb & ones;
    case (op[3:0])
      4'd0:    begin x = aa;       y = '0;       end
      4'd1:    begin x = aa | bb;  y = '0;       end
      4'd2:    begin x = aa | nb;  y = '0;       end
      4'd3:    begin x = ones;     y = '0;       end
      4'd4:    begin x = aa;       y = aa & nb;  end
      4'd5:    begin x = aa | bb;  y = aa & nb;  end
      4'd6:    begin x = aa;       y = nb;       end
      4'd7:    begin x = ones;     y = aa & nb;  end
      4'd8:    begin x = aa;       y = aa & bb;  end
      4'd9:    begin x = aa;       y = bb;       end
      4'd10:   begin x = aa | nb;  y = aa & bb;  end
      4'd11:   begin x = ones;     y = aa & bb;  end
      4'd12:   begin x = aa;       y = aa;       end
      4'd13:   begin x = aa | bb;  y = aa;       end
      4'd14:   begin x = aa | nb;  y = aa;       end
      default: begin x = ones;     y = aa;       end
    endcase
    sum   = x + y + {32'd0, ~cinN};
    coutN = ~sum[w];
    case (op[3:0])
      4'd0:    lf = na;
      4'd1:    lf = ~(aa | bb);
      4'd2:    lf = na & bb;
      4'd3:    lf = '0;
      4'd4:    lf = ~(aa & bb);
      4'd5:    lf = nb;
      4'd6:    lf = aa ^ bb;
      4'd7:    lf = aa & nb;
      4'd8:    lf = na | bb;
      4'd9:    lf = ~(aa ^ bb);
      4'd10:   lf = bb;
      4'd11:   lf = aa & bb;
      4'd12:   lf = ones;
      4'd13:   lf = aa | nb;
      4'd14:   lf = aa | bb;
      default: lf = aa;
    endcase
    f = op[4] ? lf[31:0] & ones[31:0] : sum[31:0] & ones[31:0];
  endtask

  // Offer one operation (called #1 after a rising edge while idle) and
  // count edges until out_valid, bounded so a stuck DUT still finishes.
  task automatic issue16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cinN, input logic chain, output int lat);
    if16.in_valid = 1'b1; if16.op = op; if16.a = a; if16.b = b;
    if16.cin_n = cinN; if16.chain = chain;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    lat = 0;
    while (!if16.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drain16();
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
  endtask

  task automatic issue32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cinN, input logic chain, output int lat);
    if32.in_valid = 1'b1; if32.op = op; if32.a = a; if32.b = b;
    if32.cin_n = cinN; if32.chain = chain;
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    lat = 0;
    while (!if32.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drain32();
    if32.out_ready = 1'b1;
    @(posedge clk); #1;
    if32.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if16.in_valid = 0; if16.a = '0; if16.b = '0; if16.op = '0; if16.cin_n = 1; if16.chain = 0; if16.out_ready = 0;
    if32.in_valid = 0; if32.a = '0; if32.b = '0; if32.op = '0; if32.cin_n = 1; if32.chain = 0; if32.out_ready = 0;
    expCy16 = 1'b1; expCy32 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if16.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", if16.in_ready); end
    checks++; if (if16.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", if16.out_valid); end
    checks++; if (if16.result !== 16'h0000) begin errors++; $display("[TB] FAIL reset_result got %h exp 0000", if16.result); end
    checks++; if (if16.cout_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_cout_n got %b exp 1", if16.cout_n); end
    checks++; if (if16.zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero got %b exp 0", if16.zero); end
    checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset32_in_ready got %b exp 1", if32.in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    issue16(ADD_OP, 16'hCAFE, 16'hBABE, 1'b0, 1'b0, lat);
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL add_latency got %0d exp 4", lat); end
    checks++; if (if16.result !== 16'h85BD) begin errors++; $display("[TB] FAIL add_result got %h exp 85bd", if16.result); end
    checks++; if (if16.cout_n !== 1'b0) begin errors++; $display("[TB] FAIL add_cout_n got %b exp 0", if16.cout_n); end
    checks++; if (if16.zero !== 1'b0) begin errors++; $display("[TB] FAIL add_zero got %b exp 0", if16.zero); end
    expCy16 = 1'b0;
    drain16();
  endtask

  task automatic test_sub_zero();
    int lat;
    issue16(SUB_OP, 16'h1234, 16'h1234, 1'b0, 1'b0, lat);
    checks++; if (if16.result !== 16'h0000) begin errors++; $display("[TB] FAIL sub_result got %h exp 0000", if16.result); end
    checks++; if (if16.cout_n !== 1'b0) begin errors++; $display("[TB] FAIL sub_cout_n got %b exp 0", if16.cout_n); end
    checks++; if (if16.zero !== 1'b1) begin errors++; $display("[TB] FAIL sub_zero got %b exp 1", if16.zero); end
    expCy16 = 1'b0;
    drain16();
  endtask

  task automatic test_chain();
    int lat;
    issue16(ADD_OP, 16'hFFFF, 16'h0001, 1'b1, 1'b0, lat);
    checks++; if (if16.result !== 16'h0000) begin errors++; $display("[TB] FAIL chain1_result got %h exp 0000", if16.result); end
    checks++; if (if16.cout_n !== 1'b0) begin errors++; $display("[TB] FAIL chain1_cout_n got %b exp 0", if16.cout_n); end
    drain16();
    issue16(ADD_OP, 16'h0000, 16'h0000, 1'b1, 1'b1, lat);
    checks++; if (if16.result !== 16'h0001) begin errors++; $display("[TB] FAIL chain2_result got %h exp 0001", if16.result); end
    checks++; if (if16.cout_n !== 1'b1) begin errors++; $display("[TB] FAIL chain2_cout_n got %b exp 1", if16.cout_n); end
    expCy16 = 1'b1;
    drain16();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] expF;
    logic expC;
    refModel(XOR_OP, 32'hDEAD, 32'hBEEF, 1'b1, 16, expF, expC);
    issue16(XOR_OP, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0, lat);
    if16.in_valid = 1'b1; if16.op = ADD_OP; if16.a = 16'hFFFF; if16.b = 16'h0001;
    if16.cin_n = 1'b1; if16.chain = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (if16.result !== 16'h6042) begin errors++; $display("[TB] FAIL bp_result got %h exp 6042", if16.result); end
      checks++; if (if16.cout_n !== expC) begin errors++; $display("[TB] FAIL bp_cout_n got %b exp %b", if16.cout_n, expC); end
      checks++; if (if16.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %b exp 0", if16.in_ready); end
      checks++; if (if16.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid got %b exp 1", if16.out_valid); end
    end
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
    checks++; if (if16.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_no_accept_in_done got %b exp 1", if16.in_ready); end
    checks++; if (if16.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_released got %b exp 0", if16.out_valid); end
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    checks++; if (if16.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_accept_next got %b exp 0", if16.in_ready); end
    lat = 0;
    while (!if16.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL bp2_latency got %0d exp 4", lat); end
    checks++; if (if16.result !== 16'h0000) begin errors++; $display("[TB] FAIL bp2_result got %h exp 0000", if16.result); end
    checks++; if (if16.cout_n !== 1'b0) begin errors++; $display("[TB] FAIL bp2_cout_n got %b exp 0", if16.cout_n); end
    expCy16 = 1'b0;
    drain16();
  endtask

  task automatic test_reset_midrun();
    int lat;
    if16.in_valid = 1'b1; if16.op = SUB_OP; if16.a = 16'h9999; if16.b = 16'h1111;
    if16.cin_n = 1'b0; if16.chain = 1'b0;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if16.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_out_valid got %b exp 0", if16.out_valid); end
    checks++; if (if16.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_in_ready got %b exp 1", if16.in_ready); end
    checks++; if (if16.cout_n !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_cout_n got %b exp 1", if16.cout_n); end
    checks++; if (if16.zero !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_zero got %b exp 0", if16.zero); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    expCy16 = 1'b1; expCy32 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (if16.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_no_done got %b exp 0", if16.out_valid); end
    issue16(ADD_OP, 16'h0000, 16'h0000, 1'b0, 1'b1, lat);
    checks++; if (if16.result !== 16'h0000) begin errors++; $display("[TB] FAIL mid_reset_cy_result got %h exp 0000", if16.result); end
    checks++; if (if16.cout_n !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_cy_cout_n got %b exp 1", if16.cout_n); end
    drain16();
    issue16(A_PLUS_A_OP, 16'h5432, 16'h0000, 1'b0, 1'b0, lat);
    checks++; if (if16.result !== 16'hA865) begin errors++; $display("[TB] FAIL apa_result got %h exp a865", if16.result); end
    checks++; if (if16.cout_n !== 1'b1) begin errors++; $display("[TB] FAIL apa_cout_n got %b exp 1", if16.cout_n); end
    expCy16 = 1'b1;
    drain16();
  endtask

  task automatic test_random16();
    int lat;
    logic [31:0] r, expF;
    logic [15:0] a, b;
    logic [4:0] op;
    logic cinN, chain, expC;
    for (int n = 0; n < 40; n++) begin
      r = $urandom; a = r[15:0]; b = r[31:16];
      r = $urandom; op = r[4:0]; cinN = r[5]; chain = r[6];
      if (n % 5 == 0) a = 16'hFFFF;
      refModel(op, {16'd0, a}, {16'd0, b}, chain ? expCy16 : cinN, 16, expF, expC);
      issue16(op, a, b, cinN, chain, lat);
      repeat (r[9:8]) begin @(posedge clk); #1; end
      checks++; if (lat != 4) begin errors++; $display("[TB] FAIL rnd_latency op=%h got %0d exp 4", op, lat); end
      checks++; if (if16.result !== expF[15:0]) begin errors++; $display("[TB] FAIL rnd_result op=%h a=%h b=%h got %h exp %h", op, a, b, if16.result, expF[15:0]); end
      checks++; if (if16.cout_n !== expC) begin errors++; $display("[TB] FAIL rnd_cout_n op=%h a=%h b=%h got %b exp %b", op, a, b, if16.cout_n, expC); end
      checks++; if (if16.zero !== (expF[15:0] == 16'd0)) begin errors++; $display("[TB] FAIL rnd_zero op=%h got %b exp %b", op, if16.zero, expF[15:0] == 16'd0); end
      expCy16 = expC;
      drain16();
    end
  endtask

  task automatic test_sweep32();
    int lat;
    logic [31:0] r, a, b, expF;
    logic [4:0] op;
    logic cinN, chain, expC;
    issue32(ADD_OP, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, lat);
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL w32_latency got %0d exp 4", lat); end
    checks++; if (if32.result !== 32'h0) begin errors++; $display("[TB] FAIL w32_result got %h exp 0", if32.result); end
    checks++; if (if32.cout_n !== 1'b0) begin errors++; $display("[TB] FAIL w32_cout_n got %b exp 0", if32.cout_n); end
    checks++; if (if32.zero !== 1'b1) begin errors++; $display("[TB] FAIL w32_zero got %b exp 1", if32.zero); end
    expCy32 = 1'b0;
    drain32();
    for (int n = 0; n < 20; n++) begin
      a = $urandom; b = $urandom;
      r = $urandom; op = r[4:0]; cinN = r[5]; chain = r[6];
      refModel(op, a, b, chain ? expCy32 : cinN, 32, expF, expC);
      issue32(op, a, b, cinN, chain, lat);
      checks++; if (if32.result !== expF) begin errors++; $display("[TB] FAIL w32rnd_result op=%h a=%h b=%h got %h exp %h", op, a, b, if32.result, expF); end
      checks++; if (if32.cout_n !== expC) begin errors++; $display("[TB] FAIL w32rnd_cout_n op=%h got %b exp %b", op, if32.cout_n, expC); end
      checks++; if (if32.zero !== (expF == 32'd0)) begin errors++; $display("[TB] FAIL w32rnd_zero op=%h got %b exp %b", op, if32.zero, expF == 32'd0); end
      expCy32 = expC;
      drain32();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub_zero();
    test_chain();
    test_backpressure();
    test_reset_midrun();
    test_random16();
    test_sweep32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
